uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/consumer side and the receive FIFO.
// Optional overrun counter port is present only when RX_FIFO_OVERRUN_CNT_EN is defined.
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             rd_en;
  logic             overrun_clr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overrun;
`ifdef RX_FIFO_OVERRUN_CNT_EN
  logic [7:0]       overrun_cnt;

  modport slave (
    input  wr_data, wr_en, rd_en, overrun_clr,
    output rd_data, rd_valid, empty, full, almost_full, count, overrun, overrun_cnt
  );
  modport master (
    output wr_data, wr_en, rd_en, overrun_clr,
    input  rd_data, rd_valid, empty, full, almost_full, count, overrun, overrun_cnt
  );
`else
  modport slave (
    input  wr_data, wr_en, rd_en, overrun_clr,
    output rd_data, rd_valid, empty, full, almost_full, count, overrun
  );
  modport master (
    output wr_data, wr_en, rd_en, overrun_clr,
    input  rd_data, rd_valid, empty, full, almost_full, count, overrun
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO with registered read data, fill flags and sticky overrun.
// Optional saturating dropped-write counter enabled by RX_FIFO_OVERRUN_CNT_EN.
module uart_rx_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overrun_q, overrun_d;
  logic             rd_acc_s, wr_acc_s, drop_s;
  logic             empty_s, full_s;

  assign empty_s = (count_q == CW'(0));
  assign full_s  = (count_q == CW'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  always_comb begin
    rd_acc_s   = bus.rd_en && !empty_s;
    wr_acc_s   = bus.wr_en && (!full_s || rd_acc_s);
    drop_s     = bus.wr_en && !wr_acc_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overrun_d  = overrun_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage array is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = (count_q >= CW'(AFULL_THRESH));
  assign bus.count       = count_q;
  assign bus.overrun     = overrun_q;

`ifdef RX_FIFO_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  // A drop in the same cycle as a clear restarts the count at one.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop_s && bus.overrun_clr) begin
      ovr_cnt_d = 8'd1;
    end else if (drop_s) begin
      ovr_cnt_d = (ovr_cnt_q == 8'd255) ? 8'd255 : ovr_cnt_q + 8'd1;
    end else if (bus.overrun_clr) begin
      ovr_cnt_d = 8'd0;
    end else begin
      ovr_cnt_d = ovr_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign bus.overrun_cnt = ovr_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model state
  int q[$];
  int m_data  = 0;
  int m_valid = 0;
  int m_ovr   = 0;
  int m_ocnt  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", int'(bus.count), q.size());
    chk("empty", int'(bus.empty), (q.size() == 0) ? 1 : 0);
    chk("full", int'(bus.full), (q.size() == DEPTH) ? 1 : 0);
    chk("almost_full", int'(bus.almost_full), (q.size() >= AFULL) ? 1 : 0);
    chk("rd_valid", int'(bus.rd_valid), m_valid);
    chk("rd_data", int'(bus.rd_data), m_data);
    chk("overrun", int'(bus.overrun), m_ovr);
`ifdef RX_FIFO_OVERRUN_CNT_EN
    chk("overrun_cnt", int'(bus.overrun_cnt), m_ocnt);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_data = 0; m_valid = 0; m_ovr = 0; m_ocnt = 0;
  endtask

  // One clock: drive inputs, advance model from its pre-edge state, compare.
  task automatic step(input bit wr, input int d, input bit rd, input bit clr);
    bit rd_acc, wr_acc;
    bus.wr_en = wr; bus.wr_data = d[WIDTH-1:0]; bus.rd_en = rd; bus.overrun_clr = clr;
    @(posedge clk);
    #1;
    rd_acc = rd && (q.size() > 0);
    wr_acc = wr && ((q.size() < DEPTH) || rd_acc);
    m_valid = 0;
    if (rd_acc) begin
      m_data  = q.pop_front();
      m_valid = 1;
    end
    if (wr_acc) q.push_back(d & 8'hFF);
    if (clr) m_ovr = 0;
    if (clr) m_ocnt = 0;
    if (wr && !wr_acc) begin
      m_ovr  = 1;
      m_ocnt = (m_ocnt < 255) ? m_ocnt + 1 : 255;
    end
    check_all();
  endtask

  task automatic idle(); step(1'b0, 0, 1'b0, 1'b0); endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_all();

    // Single word through
    step(1'b1, 8'h4A, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle();

    // Two fill/drain passes to exercise pointer wrap
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) step(1'b1, i + p * 8'h10, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, 1'b0);
      idle();
    end

    // Overflow: dropped write, clear, then three drops
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80 + i, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + i, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Write and read together while full
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, 1'b0);
    // Write while empty with rd_en: no fall-through
    step(1'b1, 8'h5C, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    // rd_en on empty leaves rd_data unchanged
    step(1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 7; i++) step(1'b1, 8'h20 + i, 1'b0, 1'b0);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 65), int'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
